// File: rtl/sisc_pkg.sv
// Shared SISC definitions: opcode values, instruction field positions and
// default datapath widths.
package sisc_pkg;

   localparam int PC_W_DEF  = 16;
   localparam int IR_W_DEF  = 32;
   localparam int CNT_W_DEF = 16;

   localparam logic [3:0] NOOP   = 4'd0;
   localparam logic [3:0] LOD    = 4'd1;
   localparam logic [3:0] STR    = 4'd2;
   localparam logic [3:0] SWP    = 4'd3;
   localparam logic [3:0] BRA    = 4'd4;
   localparam logic [3:0] BRR    = 4'd5;
   localparam logic [3:0] BNE    = 4'd6;
   localparam logic [3:0] BNR    = 4'd7;
   localparam logic [3:0] ALU_OP = 4'd8;
   localparam logic [3:0] HLT    = 4'd15;

   localparam int FIELD_W = 4;
   localparam int IMM_W   = 16;
   localparam int OPC_LSB = 28;
   localparam int MM_LSB  = 24;
   localparam int RD_LSB  = 20;
   localparam int RS_LSB  = 16;
   localparam int RT_LSB  = 12;
   localparam int IMM_LSB = 0;

endpackage

// File: rtl/sisc_br_calc.sv
// Combinational PC increment and branch-target generation for the SISC
// fetch stage.
module sisc_br_calc
   import sisc_pkg::*;
#(
   parameter int PC_W = PC_W_DEF
) (
   input  logic [PC_W-1:0]  pc,
   input  logic [IMM_W-1:0] imm,
   input  logic             br_sel,
   output logic [PC_W-1:0]  pc_inc,
   output logic [PC_W-1:0]  br_addr
);

   localparam int EXT_W = (PC_W > IMM_W) ? PC_W : IMM_W;

   logic [EXT_W-1:0] imm_sx;
   logic [EXT_W-1:0] imm_zx;

   // Relative offsets are two's complement; absolute targets are zero-extended.
   always_comb begin
      imm_sx  = EXT_W'($signed(imm));
      imm_zx  = EXT_W'(imm);
      pc_inc  = pc + PC_W'(1);
      br_addr = br_sel ? imm_zx[PC_W-1:0] : pc_inc + imm_sx[PC_W-1:0];
   end

endmodule

// File: rtl/sisc_fetch_unit.sv
// SISC instruction-fetch stage: PC, IR, branch target, fetched-instruction
// counter and sticky PC-wrap flag, sequenced entirely by the control FSM.
module sisc_fetch_unit
   import sisc_pkg::*;
#(
   parameter int PC_W  = PC_W_DEF,
   parameter int IR_W  = IR_W_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst_f,
   input  logic             pc_rst,
   input  logic             pc_write,
   input  logic             pc_sel,
   input  logic             br_sel,
   input  logic             ir_load,
   input  logic [IR_W-1:0]  imem_data,
   output logic [PC_W-1:0]  imem_addr,
   output logic [3:0]       opcode,
   output logic [3:0]       mm,
   output logic [3:0]       rd,
   output logic [3:0]       rs,
   output logic [3:0]       rt,
   output logic [15:0]      imm,
   output logic [PC_W-1:0]  br_addr,
   output logic [CNT_W-1:0] icount,
   output logic             pc_wrap
);

   logic [PC_W-1:0] pc;
   logic [IR_W-1:0] ir;
   logic [PC_W-1:0] pc_inc;
   logic [PC_W-1:0] next_pc;

   assign imem_addr = pc;
   assign opcode    = ir[OPC_LSB +: FIELD_W];
   assign mm        = ir[MM_LSB  +: FIELD_W];
   assign rd        = ir[RD_LSB  +: FIELD_W];
   assign rs        = ir[RS_LSB  +: FIELD_W];
   assign rt        = ir[RT_LSB  +: FIELD_W];
   assign imm       = ir[IMM_LSB +: IMM_W];

   sisc_br_calc #(
      .PC_W (PC_W)
   ) u_br_calc (
      .pc      (pc),
      .imm     (imm),
      .br_sel  (br_sel),
      .pc_inc  (pc_inc),
      .br_addr (br_addr)
   );

   assign next_pc = pc_sel ? br_addr : pc_inc;

   always_ff @(posedge clk or negedge rst_f) begin
      if (!rst_f) begin
         pc <= '0;
      end else if (pc_rst) begin
         pc <= '0;
      end else if (pc_write) begin
         pc <= next_pc;
      end
   end

   // IR survives pc_rst so a load in the same cycle still captures the old-PC word.
   always_ff @(posedge clk or negedge rst_f) begin
      if (!rst_f) begin
         ir <= '0;
      end else if (ir_load) begin
         ir <= imem_data;
      end
   end

   always_ff @(posedge clk or negedge rst_f) begin
      if (!rst_f) begin
         icount <= '0;
      end else if (pc_rst) begin
         icount <= '0;
      end else if (ir_load && (icount != '1)) begin
         icount <= icount + CNT_W'(1);
      end
   end

   // Only sequential stepping off the top address counts as a wrap.
   always_ff @(posedge clk or negedge rst_f) begin
      if (!rst_f) begin
         pc_wrap <= 1'b0;
      end else if (pc_rst) begin
         pc_wrap <= 1'b0;
      end else if (pc_write && !pc_sel && (pc == '1)) begin
         pc_wrap <= 1'b1;
      end
   end

endmodule

// File: doc/sisc_fetch_unit.md
Name: sisc_fetch_unit

Overview:
- Instruction-fetch and program-counter stage of the SISC datapath; sits directly downstream of the control FSM.
- Consumes the FSM's pc_rst, pc_write, pc_sel, br_sel and ir_load strobes.
- Holds the PC and the IR, drives the instruction-memory address, computes branch targets, and feeds opcode/mm back to the FSM.
- Also keeps a fetched-instruction counter and a sticky PC-wrap flag for debug.

Parameters:
- PC_W, 16, program counter / instruction address width
- IR_W, 32, instruction width
- CNT_W, 16, fetched-instruction counter width

Ports:
- clk  in  1  system clock, rising-edge
- rst_f  in  1  asynchronous active-low reset
- pc_rst  in  1  synchronous PC/counter clear (FSM start1)
- pc_write  in  1  load PC with selected next-PC
- pc_sel  in  1  0: next-PC = PC+1; 1: next-PC = branch target
- br_sel  in  1  0: target = PC+1+imm (relative); 1: target = imm (absolute)
- ir_load  in  1  capture imem_data into IR
- imem_data  in  IR_W  instruction word read at imem_addr
- imem_addr  out  PC_W  current PC
- opcode  out  4  IR[31:28]
- mm  out  4  IR[27:24]
- rd  out  4  IR[23:20]
- rs  out  4  IR[19:16]
- rt  out  4  IR[15:12]
- imm  out  16  IR[15:0]
- br_addr  out  PC_W  current branch target (combinational)
- icount  out  CNT_W  fetched-instruction count
- pc_wrap  out  1  sticky: PC has wrapped 0xFFFF -> 0

Behaviour:
Reset:
- rst_f low -> PC=0, IR=0, icount=0, pc_wrap=0, immediately and independent of clk.
- All field outputs are therefore 0 during reset (opcode=NOOP).

Registers update only on rising clk with rst_f high.

PC:
- Priority pc_rst > pc_write > hold.
- pc_rst: PC <= 0.
- pc_write: PC <= next_pc.
  - next_pc = PC+1 when pc_sel=0.
  - next_pc = br_addr when pc_sel=1.

Arithmetic:
- pc_inc = PC+1, modulo 2^PC_W.
- br_addr = imm[PC_W-1:0] when br_sel=1.
- br_addr = pc_inc + imm when br_sel=0, modulo 2^PC_W; imm is treated as two's-complement, so negative offsets branch backward.
- br_addr uses the current IR and PC, not next-state values.

IR:
- ir_load -> IR <= imem_data; otherwise hold.
- pc_rst does not clear IR.

Timing:
- imem_addr = PC, purely registered.
- Memory read is combinational: data for the PC presented in cycle N is captured at the end of cycle N.
- Instruction fetched in the fetch state is visible on opcode/mm in decode; the FSM branches in decode on those fields.

icount:
- pc_rst -> 0.
- Otherwise ir_load -> +1, saturating at all-ones (no wrap).

pc_wrap:
- Set when pc_write with pc_sel=0 and PC=all-ones.
- Cleared only by rst_f low or pc_rst.
- Branch targets of 0 do not set it.

Simultaneous events:
- pc_rst with pc_write -> PC=0.
- ir_load with pc_write in the same cycle -> IR captures data at the old PC; PC updates.
- ir_load with pc_rst -> IR loads, icount clears.

Reset asserted mid-operation aborts everything. On release the FSM's start1 pc_rst clears PC again (harmless).

No internal state machine beyond the registers. Sequencing is owned by the FSM.

Decomposition:
- Shared package sisc_pkg:
  - opcode constants NOOP=0, LOD=1, STR=2, SWP=3, BRA=4, BRR=5, BNE=6, BNR=7, ALU_OP=8, HLT=15
  - IR field bit positions
  - PC_W/IR_W defaults
- One natural sub-module: sisc_br_calc, the combinational PC+1 and branch-target adder/mux. PC, IR and counters remain in the top.

Test Plan:
- Reset: drive rst_f=0 mid-run with PC=0x0012 -> PC, IR, icount and pc_wrap are 0 immediately, without waiting for a clk edge.
- Sequential fetch: imem returns 0x81230000 at addr 0. Drive ir_load, then pc_write with pc_sel=0 -> opcode=8, mm=1, rd=2, rs=3, PC=1, icount=1.
- Absolute branch: PC=5, IR imm=0x0040, br_sel=1, pc_sel=1, pc_write -> br_addr=0x0040, PC=0x0040.
- Relative branch backward: PC=0x0010, imm=0xFFFC, br_sel=0, pc_sel=1, pc_write -> br_addr=0x000D, PC=0x000D.
- Wrap and saturation:
  - PC=0xFFFF, pc_write with pc_sel=0 -> PC=0, pc_wrap=1; stays 1 until pc_rst.
  - icount preset near all-ones by 0xFFFF+2 ir_loads -> holds at 0xFFFF.
- Priority: pc_rst, pc_write and ir_load asserted in the same cycle with PC=7 -> PC=0, icount=0, IR loaded with imem_data from addr 7.
